alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised, registered successor to the PIC16 combinational ALU. The W operand and the literal/f operand are `WIDTH` bits wide. It adds add-with-carry and a multi-cycle unsigned shift-add multiply. Operands are accepted on a valid/ready handshake and results are held in an output register until consumed. It sits between the decode/operand-fetch stage and the W/regfile/STATUS writeback logic.

## Interface
- `WIDTH`, 8, operand/result width; multiple of 4, ≥ 8.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands/op presented.
- `in_ready`  out  1  block accepts when `in_valid && in_ready`.
- `op`  in  4  opcode: 0 ADD, 1 SUB (lf−w), 2 AND, 3 OR, 4 XOR, 5 COM, 6 INC, 7 DEC, 8 PASSLF, 9 PASSW, A RLF, B RRF, C SWAPF, D CLR, E ADDC, F MUL.
- `op_w`  in  WIDTH  W register.
- `op_lf`  in  WIDTH  literal or register f.
- `c_in`  in  1  STATUS carry.
- `d_wr_en`  in  1  result write requested.
- `d`  in  1  destination: 0 = W, 1 = f.
- `status_wr_en`  in  1  flag writes permitted.
- `out_valid`  out  1  result register holds an unconsumed result.
- `out_ready`  in  1  consumer takes result when `out_valid && out_ready`.
- `out`  out  WIDTH  result; low half of the product for MUL.
- `out_hi`  out  WIDTH  high half of the product for MUL; 0 otherwise.
- `w_wr_en`  out  1  `d_wr_en && !d`, captured at accept.
- `f_wr_en`  out  1  `d_wr_en && d`, captured at accept.
- `z`, `dc`, `c`  out  1 each  flag values.
- `z_wr_en`, `dc_wr_en`, `c_wr_en`  out  1 each  flag write enables.

## Operation
- FSM states: IDLE, MUL, HOLD.
- `in_ready = (state==IDLE) || (state==HOLD && out_ready)`.
- All inputs are sampled only at accept. The `op` value and `status_wr_en` are captured with them.
- **Accept, non-MUL op:** the result, flags and write enables are registered; the next state is HOLD.
- **Accept, MUL:** the operands are loaded into a multiplicand/multiplier/accumulator; a bit counter is set to `WIDTH`; the next state is MUL.
- **MUL state:** each cycle, if the multiplier LSB is 1, the shifted multiplicand is added to the 2·WIDTH accumulator; the multiplier shifts right and the multiplicand shifts left; the counter decrements. When the counter reaches 0, the product is registered and the next state is HOLD.
- **HOLD:**
  - Result is presented; outputs are stable until `out_ready`.
  - On `out_ready` with no new accept, the next state is IDLE.
  - On `out_ready` with a simultaneous accept, the new op is processed as if accepted from IDLE, giving back-to-back throughput of one result per cycle.
- Write enables (`w_wr_en`, `f_wr_en`, all flag `_wr_en`) are qualifiers valid only while `out_valid`; they are 0 when `out_valid` is 0.
- Flag rules, where `S` = captured `status_wr_en`:
  - ADD/SUB/ADDC: `z`, `dc`, `c` all written under `S`.
    - ADD: `{c,out} = w + lf`.
    - ADDC: `{c,out} = w + lf + c_in`.
    - SUB: `{b,out} = lf − w`, with `c = ~b` (c = 1 means no borrow).
    - `dc` is the carry/no-borrow out of bit 3, computed on the low nibble with the same carry-in.
  - AND/OR/XOR/COM/INC/DEC/PASSLF/PASSW/CLR: only `z` written, under `S`. CLR gives `out = 0`, `z = 1`.
  - RLF: `{c,out} = {lf, c_in}`; only `c` written.
  - RRF: `{out,c} = {c_in, lf}`; only `c` written.
  - SWAPF: upper and lower WIDTH/2 halves exchanged; no flags written.
  - MUL: `{out_hi,out} = w·lf` unsigned. `z` = full product zero. `c` = (`out_hi` != 0). `z` and `c` are written under `S`; `dc_wr_en` = 0.
  - `z` reflects `out` (or the full product for MUL) for every op; `c`/`dc` are 0 when not defined by the op.
- All arithmetic wraps modulo 2^WIDTH (INC of all-ones gives 0 with z = 1; DEC of 0 gives all-ones).

## Timing
- **Reset** (async assert, sync-safe deassert): state IDLE; `out_valid`, `out`, `out_hi` and all flags and write enables are 0; `in_ready` = 1 on the first cycle after deassert.
- **Non-MUL latency:** accept at edge N; `out_valid` = 1 after edge N.
- **MUL latency:** accept at edge N; `out_valid` = 1 after edge N + WIDTH + 1; `in_ready` = 0 throughout the MUL state.
- **Reset asserted mid-MUL or in HOLD:** the op is discarded immediately; no result appears after release.
- **Backpressure:** while `out_valid && !out_ready`, every output is held bit-stable and `in_ready` = 0.

## Test plan
- ADD `w=0x3A`, `lf=0xC6`, S=1 -> `out=0x00`, `c=1`, `dc=1`, `z=1`, all three flag write enables = 1, result 1 cycle after accept.
- SUB `lf=0x03`, `w=0x05` -> `out=0xFE`, `c=0`, `dc=0`, `z=0`. Then SUB `lf=0x05`, `w=0x05` issued back-to-back with `out_ready` = 1 -> `out=0x00`, `c=1`, `dc=1`, `z=1` on the next cycle.
- MUL `0xFF × 0xFF`, `d=1`, `d_wr_en=1` -> `out_valid` exactly 9 cycles after accept; `out=0x01`, `out_hi=0xFE`, `c=1`, `z=0`, `f_wr_en=1`. Also MUL `0x0F × 0x11` -> `out=0xFF`, `out_hi=0x00`, `c=0`.
- RLF `lf=0x80`, `c_in=1` -> `out=0x01`, `c=1`, `c_wr_en=1`, `z_wr_en=0`. ADDC `0xFF + 0x00 + 1` -> `out=0x00`, `c=1`, `z=1`.
- Backpressure: XOR result held with `out_ready=0` for 3 cycles -> outputs unchanged, `in_ready=0`; released on the 4th cycle.
- Reset asserted 4 cycles into a MUL -> all outputs 0 asynchronously. After release: `in_ready=1` and `out_valid` stays 0 until a new accept.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: registered PIC16-style ALU with add-with-carry and a multi-cycle
// unsigned shift-add multiplier. Operands are taken on a valid/ready
// handshake and the result, flags and write qualifiers are held in an
// output register until the writeback stage consumes them.
module alu_mc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] op_w,
   input  logic [WIDTH-1:0] op_lf,
   input  logic             c_in,
   input  logic             d_wr_en,
   input  logic             d,
   input  logic             status_wr_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             w_wr_en,
   output logic             f_wr_en,
   output logic             z,
   output logic             dc,
   output logic             c,
   output logic             z_wr_en,
   output logic             dc_wr_en,
   output logic             c_wr_en
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int HW = WIDTH / 2;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

   typedef enum logic [3:0] {
      OP_ADD = 4'h0, OP_SUB  = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3,
      OP_XOR = 4'h4, OP_COM  = 4'h5, OP_INC = 4'h6, OP_DEC  = 4'h7,
      OP_PLF = 4'h8, OP_PW   = 4'h9, OP_RLF = 4'hA, OP_RRF  = 4'hB,
      OP_SWP = 4'hC, OP_CLR  = 4'hD, OP_ADC = 4'hE, OP_MUL  = 4'hF
   } op_t;

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               s_q;
   logic               w_wr_q;
   logic               f_wr_q;

   logic               accept;
   logic [WIDTH-1:0]   r_out;
   logic               r_c;
   logic               r_dc;
   logic               r_z;
   logic               r_z_wr;
   logic               r_dc_wr;
   logic               r_c_wr;
   logic [WIDTH:0]     sum;
   logic [4:0]         nib;

   // Ready when idle, or when the held result is being consumed this cycle.
   assign in_ready  = (state == S_IDLE) || (state == S_HOLD && out_ready);
   assign out_valid = (state == S_HOLD);
   assign accept    = in_valid && in_ready;

   // Single-cycle ALU result and flags for every non-multiply opcode.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
      r_out   = '0;
      r_c     = 1'b0;
      r_dc    = 1'b0;
      r_z_wr  = 1'b0;
      r_dc_wr = 1'b0;
      r_c_wr  = 1'b0;
      sum     = '0;
      nib     = '0;
      case (op_t'(op))
         OP_ADD: begin
            sum   = {1'b0, op_w} + {1'b0, op_lf};
            nib   = {1'b0, op_w[3:0]} + {1'b0, op_lf[3:0]};
            r_out = sum[WIDTH-1:0];
            r_c   = sum[WIDTH];
            r_dc  = nib[4];
            r_z_wr = 1'b1; r_dc_wr = 1'b1; r_c_wr = 1'b1;
         end
         OP_ADC: begin
            sum   = {1'b0, op_w} + {1'b0, op_lf} + {{WIDTH{1'b0}}, c_in};
            nib   = {1'b0, op_w[3:0]} + {1'b0, op_lf[3:0]} + {4'b0000, c_in};
            r_out = sum[WIDTH-1:0];
            r_c   = sum[WIDTH];
            r_dc  = nib[4];
            r_z_wr = 1'b1; r_dc_wr = 1'b1; r_c_wr = 1'b1;
         end
         OP_SUB: begin
            // lf + ~w + 1: the carry out is the inverted borrow.
            sum   = {1'b0, op_lf} + {1'b0, ~op_w} + {{WIDTH{1'b0}}, 1'b1};
            nib   = {1'b0, op_lf[3:0]} + {1'b0, ~op_w[3:0]} + 5'd1;
            r_out = sum[WIDTH-1:0];
            r_c   = sum[WIDTH];
            r_dc  = nib[4];
            r_z_wr = 1'b1; r_dc_wr = 1'b1; r_c_wr = 1'b1;
         end
         OP_AND: begin r_out = op_w & op_lf; r_z_wr = 1'b1; end
         OP_OR:  begin r_out = op_w | op_lf; r_z_wr = 1'b1; end
         OP_XOR: begin r_out = op_w ^ op_lf; r_z_wr = 1'b1; end
         OP_COM: begin r_out = ~op_lf;       r_z_wr = 1'b1; end
         OP_INC: begin r_out = op_lf + ONE;  r_z_wr = 1'b1; end
         OP_DEC: begin r_out = op_lf - ONE;  r_z_wr = 1'b1; end
         OP_PLF: begin r_out = op_lf;        r_z_wr = 1'b1; end
         OP_PW:  begin r_out = op_w;         r_z_wr = 1'b1; end
         OP_CLR: begin r_out = '0;           r_z_wr = 1'b1; end
         OP_RLF: begin
            r_out  = {op_lf[WIDTH-2:0], c_in};
            r_c    = op_lf[WIDTH-1];
            r_c_wr = 1'b1;
         end
         OP_RRF: begin
            r_out  = {c_in, op_lf[WIDTH-1:1]};
            r_c    = op_lf[0];
            r_c_wr = 1'b1;
         end
         OP_SWP: r_out = {op_lf[HW-1:0], op_lf[WIDTH-1:HW]};
         default: r_out = '0;
      endcase
      r_z = (r_out == '0);
   end

   // Control FSM, shift-add multiplier datapath and the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         s_q      <= 1'b0;
         w_wr_q   <= 1'b0;
         f_wr_q   <= 1'b0;
         out      <= '0;
         out_hi   <= '0;
         z        <= 1'b0;
         dc       <= 1'b0;
         c        <= 1'b0;
         w_wr_en  <= 1'b0;
         f_wr_en  <= 1'b0;
         z_wr_en  <= 1'b0;
         dc_wr_en <= 1'b0;
         c_wr_en  <= 1'b0;
      end else if (state == S_MUL) begin
         if (cnt == '0) begin
            out      <= acc[WIDTH-1:0];
            out_hi   <= acc[2*WIDTH-1:WIDTH];
            z        <= (acc == '0);
            dc       <= 1'b0;
            c        <= |acc[2*WIDTH-1:WIDTH];
            z_wr_en  <= s_q;
            dc_wr_en <= 1'b0;
            c_wr_en  <= s_q;
            w_wr_en  <= w_wr_q;
            f_wr_en  <= f_wr_q;
            state    <= S_HOLD;
         end else begin
            // NOTE: non-blocking assignments here so every register samples the pre-edge values of the others.
            if (mplier[0]) acc <= acc + mcand;
            mplier <= mplier >> 1;
            mcand  <= mcand << 1;
            cnt    <= cnt - CW'(1);
         end
      end else if (accept) begin
         if (op == OP_MUL) begin
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, op_w};
            mplier   <= op_lf;
            cnt      <= CW'(WIDTH);
            s_q      <= status_wr_en;
            w_wr_q   <= d_wr_en && !d;
            f_wr_q   <= d_wr_en && d;
            w_wr_en  <= 1'b0;
            f_wr_en  <= 1'b0;
            z_wr_en  <= 1'b0;
            dc_wr_en <= 1'b0;
            c_wr_en  <= 1'b0;
            state    <= S_MUL;
         end else begin
            out      <= r_out;
            out_hi   <= '0;
            z        <= r_z;
            dc       <= r_dc;
            c        <= r_c;
            z_wr_en  <= status_wr_en && r_z_wr;
            dc_wr_en <= status_wr_en && r_dc_wr;
            c_wr_en  <= status_wr_en && r_c_wr;
            w_wr_en  <= d_wr_en && !d;
            f_wr_en  <= d_wr_en && d;
            state    <= S_HOLD;
         end
      end else if (state == S_HOLD && out_ready) begin
         // Result consumed with nothing new: qualifiers drop with out_valid.
         w_wr_en  <= 1'b0;
         f_wr_en  <= 1'b0;
         z_wr_en  <= 1'b0;
         dc_wr_en <= 1'b0;
         c_wr_en  <= 1'b0;
         state    <= S_IDLE;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH = 8): directed vectors with
// hand-computed results pushed to a scoreboard, popped by a monitor
// whenever a result is consumed.
module tb_alu_mc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] op;
   logic [7:0] op_w;
   logic [7:0] op_lf;
   logic       c_in;
   logic       d_wr_en;
   logic       d;
   logic       status_wr_en;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out;
   logic [7:0] out_hi;
   logic       w_wr_en, f_wr_en, z, dc, c, z_wr_en, dc_wr_en, c_wr_en;

   // out, out_hi, z, dc, c, z_wr, dc_wr, c_wr, w_wr, f_wr
   typedef struct packed {
      logic [7:0] o;
      logic [7:0] hi;
      logic       z, dc, c, zwr, dcwr, cwr, wwr, fwr;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   alu_mc #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .op_w(op_w), .op_lf(op_lf), .c_in(c_in), .d_wr_en(d_wr_en),
      .d(d), .status_wr_en(status_wr_en), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .out_hi(out_hi), .w_wr_en(w_wr_en),
      .f_wr_en(f_wr_en), .z(z), .dc(dc), .c(c), .z_wr_en(z_wr_en),
      .dc_wr_en(dc_wr_en), .c_wr_en(c_wr_en)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input logic [7:0] o, hi,
                               input logic ez, edc, ec, zw, dcw, cw, ww, fw);
      mk = '{o: o, hi: hi, z: ez, dc: edc, c: ec, zwr: zw, dcwr: dcw,
             cwr: cw, wwr: ww, fwr: fw};
   endfunction

   function automatic exp_t act();
      act = '{o: out, hi: out_hi, z: z, dc: dc, c: c, zwr: z_wr_en,
              dcwr: dc_wr_en, cwr: c_wr_en, wwr: w_wr_en, fwr: f_wr_en};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endtask

   // Monitor: compare each consumed result against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 32'(out_valid), 32'(0));
            end else begin
               e = sb.pop_front();
               check("result", 32'(act()), 32'(e));
            end
         end
      end
   end

   // Present one operation and wait (bounded) for it to be accepted.
   task automatic issue(input logic [3:0] o, input logic [7:0] w, lf,
                        input logic ci, dwr, dd, s, input exp_t e, input bit push);
      bit got = 0;
      bit rdy;
      op = o; op_w = w; op_lf = lf; c_in = ci; d_wr_en = dwr; d = dd;
      status_wr_en = s; in_valid = 1'b1;
      if (push) sb.push_back(e);
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         if (rdy) got = 1;
      end
      #1;
      in_valid = 1'b0;
      if (!got) check("accept_timeout", 32'(got), 32'(1));
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int   k;
      int   c1, c2;
      bit   ir_seen;
      bit   ov_seen;
      exp_t ex;

      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "global timeout");
   end

   initial begin
      int   k;
      int   c1, c2;
      bit   ir_seen;
      bit   ov_seen;
      exp_t ex;

      rst_n = 1'b0; in_valid = 1'b0; op = '0; op_w = '0; op_lf = '0;
      c_in = 1'b0; d_wr_en = 1'b0; d = 1'b0; status_wr_en = 1'b0;
      out_ready = 1'b1;
      #3;
      check("reset_outputs", 32'(act()), 32'(0));
      check("reset_out_valid", 32'(out_valid), 32'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_in_ready", 32'(in_ready), 32'(1));

      // ADD 0x3A + 0xC6 = 0x100
      issue(4'h0, 8'h3A, 8'hC6, 1'b0, 1'b1, 1'b0, 1'b1,
            mk(8'h00, 8'h00, 1, 1, 1, 1, 1, 1, 1, 0), 1);
      check("add_latency", 32'(out_valid), 32'(1));

      // SUB 0x03 - 0x05 then 0x05 - 0x05 back-to-back
      issue(4'h1, 8'h05, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1,
            mk(8'hFE, 8'h00, 0, 0, 0, 1, 1, 1, 0, 1), 1);
      c1 = cyc;
      issue(4'h1, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1,
            mk(8'h00, 8'h00, 1, 1, 1, 1, 1, 1, 0, 0), 1);
      c2 = cyc;
      check("b2b_accept_gap", 32'(c2 - c1), 32'(1));
      drain();

      // MUL 0xFF * 0xFF = 0xFE01, latency 9
      issue(4'hF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1,
            mk(8'h01, 8'hFE, 0, 0, 1, 1, 0, 1, 0, 1), 1);
      k = 0; ir_seen = 0;
      while (!out_valid && k < 30) begin
         if (in_ready) ir_seen = 1;
         @(posedge clk); #1;
         k++;
      end
      check("mul_latency", 32'(k), 32'(9));
      check("mul_in_ready_low", 32'(ir_seen), 32'(0));
      drain();

      // MUL 0x0F * 0x11 = 0x00FF
      issue(4'hF, 8'h0F, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1,
            mk(8'hFF, 8'h00, 0, 0, 0, 1, 0, 1, 1, 0), 1);
      // MUL 0x00 * 0x05 = 0, z set
      issue(4'hF, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1,
            mk(8'h00, 8'h00, 1, 0, 0, 1, 0, 1, 0, 0), 1);
      drain();

      // RLF 0x80 with c_in=1 -> 0x01, c=1
      issue(4'hA, 8'h00, 8'h80, 1'b1, 1'b1, 1'b1, 1'b1,
            mk(8'h01, 8'h00, 0, 0, 1, 0, 0, 1, 0, 1), 1);
      // ADDC 0xFF + 0x00 + 1 -> 0x00, c=1, dc=1, z=1
      issue(4'hE, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1,
            mk(8'h00, 8'h00, 1, 1, 1, 1, 1, 1, 1, 0), 1);
      // INC 0xFF wraps to 0
      issue(4'h6, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1,
            mk(8'h00, 8'h00, 1, 0, 0, 1, 0, 0, 0, 1), 1);
      // DEC 0x00 wraps to 0xFF
      issue(4'h7, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1,
            mk(8'hFF, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0), 1);
      // SWAPF 0xA5 -> 0x5A, no flag writes
      issue(4'hC, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1,
            mk(8'h5A, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1), 1);
      // RRF 0x01 with c_in=0 -> 0x00, c=1, z reflects out
      issue(4'hB, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1,
            mk(8'h00, 8'h00, 1, 0, 1, 0, 0, 1, 0, 1), 1);
      // CLR with flag writes disabled
      issue(4'hD, 8'h33, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0,
            mk(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1), 1);
      // COM 0x0F -> 0xF0
      issue(4'h5, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1,
            mk(8'hF0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0), 1);
      // ADD 0x01 + 0x02 with S=0: no flag enables
      issue(4'h0, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0,
            mk(8'h03, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0), 1);
      drain();

      // Backpressure: XOR 0x5A ^ 0x0F = 0x55 held three cycles
      out_ready = 1'b0;
      ex = mk(8'h55, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0);
      issue(4'h4, 8'h5A, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, ex, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_hold_outputs", 32'(act()), 32'(ex));
         check("bp_in_ready", 32'({out_valid, in_ready}), 32'(2'b10));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      drain();

      // Reset four cycles into a MUL: discarded, outputs cleared at once
      issue(4'hF, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 1'b1, ex, 0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midmul_reset_outputs", 32'(act()), 32'(0));
      check("midmul_reset_valid", 32'(out_valid), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midmul_post_in_ready", 32'(in_ready), 32'(1));
      ov_seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (out_valid) ov_seen = 1;
      end
      check("midmul_no_result", 32'(ov_seen), 32'(0));

      // Normal operation after reset: OR 0x50 | 0x0A = 0x5A
      issue(4'h3, 8'h50, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b1,
            mk(8'h5A, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0), 1);
      drain();

      check("scoreboard_empty", 32'(sb.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
